// File: rtl/obj_loader.sv
// obj_loader: decodes a PAL binary-format byte stream into 12-bit words and writes them to memory.
// Define LOADER_CHECKSUM_EN to delay each word by one slot and verify the trailing checksum word.
module obj_loader (
    input  logic        clk,
    input  logic        btnCpuReset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic        mem_finished,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {LEADER, HI, LO, WRITE, WAIT_ACK, DONE} state_t;

    state_t      state, state_next;
    logic [6:0]  high_byte;
    logic [11:0] addr;
    logic [11:0] word_reg;
    logic        accept, hi_take, lo_ok, lo_bad, trailer;
    logic [11:0] word_now;
    logic        proc_valid, proc_origin;
    logic [11:0] proc_word;
    logic        sum_fault;

    assign in_ready = (state == LEADER) || (state == HI) || (state == LO);
    assign busy     = (state == HI) || (state == LO) || (state == WRITE) || (state == WAIT_ACK);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign hi_take  = accept && !in_data[7] && ((state == LEADER) || (state == HI));
    assign lo_ok    = accept && (state == LO) && !in_data[7] && !in_data[6];
    assign lo_bad   = accept && (state == LO) && (in_data[7] || in_data[6]);
    assign trailer  = accept && (state == HI) && in_data[7];
    assign word_now = {high_byte[5:0], in_data[5:0]};

`ifdef LOADER_CHECKSUM_EN
    // The most recent word stays pending; whichever word is pending at the trailer is the checksum.
    logic [11:0] checksum;
    logic [11:0] pend_word;
    logic [11:0] pend_sum;
    logic        pend_origin;
    logic        pend_valid;

    assign proc_valid  = lo_ok && pend_valid;
    assign proc_word   = pend_word;
    assign proc_origin = pend_origin;
    assign sum_fault   = trailer && (!pend_valid || (pend_word != (checksum - pend_sum)));

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            checksum    <= '0;
            pend_word   <= '0;
            pend_sum    <= '0;
            pend_origin <= 1'b0;
            pend_valid  <= 1'b0;
        end else if (lo_bad) begin
            checksum   <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (hi_take || lo_ok)
                checksum <= checksum + {4'd0, in_data};
            if (lo_ok) begin
                pend_word   <= word_now;
                pend_origin <= high_byte[6];
                pend_sum    <= {5'd0, high_byte} + {6'd0, in_data[5:0]};
                pend_valid  <= 1'b1;
            end
        end
    end
`else
    assign proc_valid  = lo_ok;
    assign proc_word   = word_now;
    assign proc_origin = high_byte[6];
    assign sum_fault   = 1'b0;
`endif

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset)
            state <= LEADER;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LEADER:   if (hi_take) state_next = LO;
            HI: begin
                if (trailer)
                    state_next = DONE;
                else if (hi_take)
                    state_next = LO;
            end
            LO: begin
                if (lo_bad)
                    state_next = LEADER;
                else if (lo_ok)
                    state_next = (proc_valid && !proc_origin) ? WRITE : HI;
            end
            WRITE:    state_next = WAIT_ACK;
            WAIT_ACK: if (mem_finished) state_next = HI;
            DONE:     state_next = DONE;
            default:  state_next = LEADER;
        endcase
    end

    // Memory outputs are registered so they stay frozen for the whole handshake.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            high_byte        <= '0;
            addr             <= '0;
            word_reg         <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            error            <= 1'b0;
        end else begin
            if (hi_take)
                high_byte <= in_data[6:0];
            if (proc_valid) begin
                if (proc_origin)
                    addr <= proc_word;
                else
                    word_reg <= proc_word;
            end
            if (state == WRITE) begin
                mem_address      <= addr;
                mem_write_data   <= word_reg;
                mem_write_enable <= 1'b1;
            end else if ((state == WAIT_ACK) && mem_finished) begin
                mem_write_enable <= 1'b0;
                addr             <= addr + 12'd1;
            end
            if (lo_bad || sum_fault)
                error <= 1'b1;
        end
    end

endmodule
